// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB requester: FSM state encoding and timing defaults.
// The bench imports this too, so the two always agree on the default timeout.
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    localparam int DEFAULT_TIMEOUT = 15;
    localparam int WAIT_CNT_WIDTH  = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready. expired flags the cycle in
// which this wait brings the count up to TIMEOUT.
module apb_wait_timer
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [WAIT_CNT_WIDTH-1:0] LAST_WAIT = WAIT_CNT_WIDTH'(TIMEOUT - 1);

    logic [WAIT_CNT_WIDTH-1:0] count;

    always_ff @(posedge pclk) begin
        if (preset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + WAIT_CNT_WIDTH'(1);
        end
    end

    // The increment made in this cycle is the one that hits TIMEOUT.
    assign expired = en && (count == LAST_WAIT);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: takes one command, runs SETUP/ACCESS with a
// pready timeout, and holds the response until it is consumed.
//
// state  | meaning
// IDLE   | ready for a command, bus idle
// SETUP  | pselx=1, penable=0 for one cycle
// ACCESS | pselx=1, penable=1, waiting for pready or timeout
// RESP   | rsp_valid=1 until rsp_ready
module apb_master
    import apb_master_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic                  pselx,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);

    apb_state_t state, state_next;
    logic       expired;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .pclk    (pclk),
        .preset  (preset),
        .clear   (state == ST_SETUP),
        .en      ((state == ST_ACCESS) && !pready),
        .expired (expired)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (cmd_valid) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (pready || expired) state_next = ST_RESP;
            ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state == ST_IDLE);
    assign pselx     = (state == ST_SETUP) || (state == ST_ACCESS);
    assign penable   = (state == ST_ACCESS);
    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge pclk) begin
        if (preset) begin
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && cmd_valid) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
            end
            // pready takes priority over a timeout landing in the same cycle.
            if ((state == ST_ACCESS) && pready) begin
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= 1'b0;
            end else if ((state == ST_ACCESS) && expired) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule
